// File: rtl/cmos_pixel_packer.sv
// Packs RATIO consecutive IN_W-bit sensor beats into one wide word and tags it with
// start-of-line, start-of-frame, end-of-line and partial-word markers (pclk domain only).
module cmos_pixel_packer #(
    parameter int              IN_W          = 8,
    parameter int              RATIO         = 2,
    parameter int              FIRST_LOW     = 1,
    parameter int              FLUSH_PARTIAL = 1,
    parameter logic [IN_W-1:0] PAD_VALUE     = '0
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic                  vsync_i,
    input  logic                  de_i,
    input  logic [IN_W-1:0]       pdata_i,
    output logic [IN_W*RATIO-1:0] pdata_o,
    output logic                  de_o,
    output logic                  sol_o,
    output logic                  sof_o,
    output logic                  eol_o,
    output logic                  partial_o,
    output logic [15:0]           line_words_o,
    output logic [7:0]            drop_cnt_o
);

    localparam int              CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int              OUT_W = IN_W * RATIO;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(RATIO - 1);

    logic [CNT_W-1:0] cnt;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] merged;
    logic [OUT_W-1:0] padded;
    logic             de_d;
    logic             sof_arm;
    logic             sol_arm;
    logic [15:0]      run_cnt;

    function automatic int slot_base(input int k);
        return ((FIRST_LOW != 0) ? k : (RATIO - 1 - k)) * IN_W;
    endfunction

    // merged: accumulator with the current beat dropped into slot cnt.
    // padded: accumulator with every slot at or above cnt replaced by the pad value,
    // since those slots still hold beats of the previous word.
    always_comb begin
        merged = acc;
        padded = acc;
        for (int k = 0; k < RATIO; k++) begin
            if (cnt == CNT_W'(k)) begin
                merged[slot_base(k) +: IN_W] = pdata_i;
            end
            if (CNT_W'(k) >= cnt) begin
                padded[slot_base(k) +: IN_W] = PAD_VALUE;
            end
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            acc          <= '0;
            de_d         <= 1'b0;
            sof_arm      <= 1'b0;
            sol_arm      <= 1'b1;
            run_cnt      <= '0;
            pdata_o      <= '0;
            de_o         <= 1'b0;
            sol_o        <= 1'b0;
            sof_o        <= 1'b0;
            eol_o        <= 1'b0;
            partial_o    <= 1'b0;
            line_words_o <= '0;
            drop_cnt_o   <= '0;
        end else begin
            de_o      <= 1'b0;
            sol_o     <= 1'b0;
            sof_o     <= 1'b0;
            eol_o     <= 1'b0;
            partial_o <= 1'b0;
            if (vsync_i) begin
                cnt     <= '0;
                acc     <= '0;
                de_d    <= 1'b0;
                run_cnt <= '0;
                sof_arm <= 1'b1;
                sol_arm <= 1'b1;
            end else begin
                de_d <= de_i;
                if (de_i) begin
                    acc <= merged;
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        pdata_o <= merged;
                        de_o    <= 1'b1;
                        sol_o   <= sol_arm;
                        sof_o   <= sof_arm;
                        sol_arm <= 1'b0;
                        sof_arm <= 1'b0;
                        run_cnt <= run_cnt + 16'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else if (de_d) begin
                    // Line end: report the count, then flush or drop any partial word.
                    eol_o        <= 1'b1;
                    cnt          <= '0;
                    run_cnt      <= '0;
                    sol_arm      <= 1'b1;
                    line_words_o <= run_cnt;
                    if (cnt != '0) begin
                        if (FLUSH_PARTIAL != 0) begin
                            pdata_o      <= padded;
                            de_o         <= 1'b1;
                            partial_o    <= 1'b1;
                            sol_o        <= sol_arm;
                            sof_o        <= sof_arm;
                            sof_arm      <= 1'b0;
                            line_words_o <= run_cnt + 16'd1;
                        end else if (drop_cnt_o != 8'hFF) begin
                            drop_cnt_o <= drop_cnt_o + 8'd1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cmos_pixel_packer.sv
// Drives four differently parametrised packers from one sensor stream and compares each
// against a line-level model built from a queue of the beats seen in the current line.
module tb_cmos_pixel_packer;

    localparam int         N         = 4;
    localparam int         RS[N]     = '{2, 2, 4, 4};
    localparam int         FLS[N]    = '{1, 0, 1, 0};
    localparam int         FLUSHS[N] = '{1, 0, 1, 0};
    localparam logic [7:0] PADS[N]   = '{8'h00, 8'hAA, 8'hFF, 8'h5A};

    typedef struct packed {
        logic       vs;
        logic       de;
        logic [7:0] d;
    } stim_t;

    logic        pclk = 1'b0;
    logic        rst;
    logic        vsync_i;
    logic        de_i;
    logic [7:0]  pdata_i;
    logic [60:0] obs [N];

    int checks   = 0;
    int failures = 0;

    always #5 pclk = ~pclk;

    // obs packs {pdata(32), de, sol, sof, eol, partial, line_words(16), drop(8)}
    for (genvar g = 0; g < N; g++) begin : g_dut
        logic [8*RS[g]-1:0] pd;
        logic               de, sol, sof, eol, par;
        logic [15:0]        lw;
        logic [7:0]         dc;
        cmos_pixel_packer #(
            .IN_W(8), .RATIO(RS[g]), .FIRST_LOW(FLS[g]),
            .FLUSH_PARTIAL(FLUSHS[g]), .PAD_VALUE(PADS[g])
        ) dut (
            .pclk(pclk), .rst(rst), .vsync_i(vsync_i), .de_i(de_i), .pdata_i(pdata_i),
            .pdata_o(pd), .de_o(de), .sol_o(sol), .sof_o(sof), .eol_o(eol),
            .partial_o(par), .line_words_o(lw), .drop_cnt_o(dc)
        );
        assign obs[g] = {32'(pd), de, sol, sof, eol, par, lw, dc};
    end

    // Reference model: beats of the current line plus per-instance bookkeeping.
    logic [7:0]  line_q [$];
    stim_t       stim_q [$];
    logic [31:0] m_pd [N];
    bit          m_de [N], m_sol [N], m_sof [N], m_eol [N], m_par [N];
    bit          m_solp [N], m_sofp [N];
    int          m_words [N], m_lw [N], m_drop [N];

    function automatic logic [60:0] exp_vec(input int i);
        return {m_pd[i], m_de[i], m_sol[i], m_sof[i], m_eol[i], m_par[i],
                16'(m_lw[i]), 8'(m_drop[i])};
    endfunction

    // Word built from the last n beats of the line, unfilled slots padded.
    function automatic logic [31:0] pack(input int i, input int n);
        logic [31:0] w;
        logic [7:0]  b;
        int          pos;
        int          sz;
        w  = '0;
        sz = line_q.size();
        for (int k = 0; k < RS[i]; k++) begin
            b   = (k < n) ? line_q[sz - n + k] : PADS[i];
            pos = (FLS[i] != 0) ? k : RS[i] - 1 - k;
            w[pos*8 +: 8] = b;
        end
        return w;
    endfunction

    function automatic void emit(input int i, input logic [31:0] w, input bit part);
        m_pd[i]   = w;
        m_de[i]   = 1'b1;
        m_par[i]  = part;
        m_sol[i]  = m_solp[i];
        m_sof[i]  = m_sofp[i];
        m_solp[i] = 1'b0;
        m_sofp[i] = 1'b0;
        m_words[i]++;
    endfunction

    function automatic void model_reset();
        line_q.delete();
        for (int i = 0; i < N; i++) begin
            m_pd[i] = '0; m_de[i] = 0; m_sol[i] = 0; m_sof[i] = 0; m_eol[i] = 0; m_par[i] = 0;
            m_solp[i] = 1; m_sofp[i] = 0; m_words[i] = 0; m_lw[i] = 0; m_drop[i] = 0;
        end
    endfunction

    function automatic void model_edge(input logic vs, input logic de, input logic [7:0] d);
        int rem;
        for (int i = 0; i < N; i++) begin
            m_de[i] = 0; m_sol[i] = 0; m_sof[i] = 0; m_eol[i] = 0; m_par[i] = 0;
        end
        if (vs) begin
            line_q.delete();
            for (int i = 0; i < N; i++) begin
                m_words[i] = 0; m_solp[i] = 1; m_sofp[i] = 1;
            end
        end else if (de) begin
            line_q.push_back(d);
            for (int i = 0; i < N; i++)
                if (line_q.size() % RS[i] == 0) emit(i, pack(i, RS[i]), 1'b0);
        end else if (line_q.size() > 0) begin
            for (int i = 0; i < N; i++) begin
                m_eol[i] = 1;
                rem = line_q.size() % RS[i];
                if (rem != 0) begin
                    if (FLUSHS[i] != 0) emit(i, pack(i, rem), 1'b1);
                    else if (m_drop[i] < 255) m_drop[i]++;
                end
                m_lw[i]    = m_words[i];
                m_words[i] = 0;
                m_solp[i]  = 1;
            end
            line_q.delete();
        end
    endfunction

    task automatic cycle(input logic vs, input logic de, input logic [7:0] d);
        vsync_i = vs;
        de_i    = de;
        pdata_i = d;
        @(posedge pclk);
        model_edge(vs, de, d);
        #1;
    endtask

    function automatic void push(input logic vs, input logic de, input logic [7:0] d);
        stim_q.push_back(stim_t'({vs, de, d}));
    endfunction

    function automatic void push_line(input int n, input bit rnd);
        for (int k = 0; k < n; k++) push(1'b0, 1'b1, rnd ? 8'($urandom) : 8'(8'hA1 + k));
    endfunction

    task automatic test_reset();
        rst = 1'b1; vsync_i = 1'b0; de_i = 1'b0; pdata_i = '0;
        model_reset();
        #3;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (obs[i] !== 61'd0) begin
                failures++;
                $display("[TB] FAIL reset_inst%0d: got %h need %h", i, obs[i], 61'd0);
            end
        end
        repeat (2) @(posedge pclk);
        #2 rst = 1'b0;
    endtask

    task automatic test_packing();
        cycle(0, 1, 8'h11);
        cycle(0, 1, 8'h22);
        checks++;
        if (obs[0][60:28] !== {32'h2211, 1'b1} || obs[0][27] !== 1'b1) begin
            failures++; $display("[TB] FAIL pack_lo_word1: got %h need 2211 de=1 sol=1", obs[0][60:27]);
        end
        checks++;
        if (obs[1][60:28] !== {32'h1122, 1'b1}) begin
            failures++; $display("[TB] FAIL pack_hi_word1: got %h need 1122 de=1", obs[1][60:28]);
        end
        cycle(0, 1, 8'h33);
        cycle(0, 1, 8'h44);
        checks++;
        if (obs[0][60:27] !== {32'h4433, 1'b1, 1'b0}) begin
            failures++; $display("[TB] FAIL pack_lo_word2: got %h need 4433 de=1 sol=0", obs[0][60:27]);
        end
        checks++;
        if (obs[1][60:29] !== 32'h3344) begin
            failures++; $display("[TB] FAIL pack_hi_word2: got %h need 3344", obs[1][60:29]);
        end
        checks++;
        if (obs[2][60:29] !== 32'h44332211 || obs[3][60:29] !== 32'h11223344) begin
            failures++; $display("[TB] FAIL pack_r4_word: got %h/%h need 44332211/11223344",
                                 obs[2][60:29], obs[3][60:29]);
        end
        cycle(0, 0, 8'h00);
        checks++;
        if (obs[0][28:8] !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2}) begin
            failures++; $display("[TB] FAIL pack_eol_lo: got %h need eol=1 line_words=2", obs[0][28:8]);
        end
        checks++;
        if (obs[2][23:8] !== 16'd1) begin
            failures++; $display("[TB] FAIL pack_lw_r4: got %0d need 1", obs[2][23:8]);
        end
        for (int k = 1; k <= 4; k++) cycle(0, 1, 8'(k));
        checks++;
        if (obs[2][60:27] !== {32'h04030201, 1'b1, 1'b1}) begin
            failures++; $display("[TB] FAIL pack_r4_full: got %h need 04030201 de=1 sol=1", obs[2][60:27]);
        end
        cycle(0, 1, 8'h05);
        cycle(0, 1, 8'h06);
        cycle(0, 0, 8'h00);
        checks++;
        if (obs[2][60:8] !== {32'hFFFF0605, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2}) begin
            failures++; $display("[TB] FAIL pack_flush: got %h need FFFF0605 de sol=0 eol partial lw=2", obs[2][60:8]);
        end
        checks++;
        if (obs[3][28] !== 1'b0 || obs[3][25] !== 1'b1 || obs[3][7:0] !== 8'd1) begin
            failures++; $display("[TB] FAIL pack_drop: got de=%b eol=%b drop=%0d need 0 1 1",
                                 obs[3][28], obs[3][25], obs[3][7:0]);
        end
        checks++;
        if (obs[1][23:8] !== 16'd3 || obs[1][24] !== 1'b0) begin
            failures++; $display("[TB] FAIL pack_lw_r2: got lw=%0d partial=%b need 3 0", obs[1][23:8], obs[1][24]);
        end
    endtask

    task automatic test_vsync();
        stim_t s;
        push(1, 0, 0); push(1, 1, 8'h77);
        push_line(4, 1); push(0, 0, 0);
        push_line(1, 1); push(1, 1, 8'h55); push(0, 0, 0);
        push_line(4, 1); push(0, 0, 0);
        push_line(3, 1); push(1, 0, 0); push(0, 0, 0);
        push_line(5, 1); push(0, 0, 0); push(0, 0, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            cycle(s.vs, s.de, s.d);
            for (int i = 0; i < N; i++) begin
                checks++;
                if (obs[i] !== exp_vec(i)) begin
                    failures++;
                    $display("[TB] FAIL vsync_inst%0d: got %h need %h", i, obs[i], exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_drop_saturation();
        stim_t s;
        for (int l = 0; l < 300; l++) begin
            push_line(6, 1);
            push(0, 0, 0);
        end
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            cycle(s.vs, s.de, s.d);
            for (int i = 0; i < N; i++) begin
                checks++;
                if (obs[i] !== exp_vec(i)) begin
                    failures++;
                    $display("[TB] FAIL drop_inst%0d: got %h need %h", i, obs[i], exp_vec(i));
                end
            end
        end
        checks++;
        if (obs[3][7:0] !== 8'd255) begin
            failures++; $display("[TB] FAIL drop_saturate: got %0d need 255", obs[3][7:0]);
        end
    endtask

    task automatic test_reset_midword();
        stim_t s;
        cycle(0, 1, 8'hAB);
        #2 rst = 1'b1;
        de_i = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (obs[i] !== 61'd0) begin
                failures++;
                $display("[TB] FAIL midreset_inst%0d: got %h need %h", i, obs[i], 61'd0);
            end
        end
        model_reset();
        @(posedge pclk);
        #2 rst = 1'b0;
        push_line(4, 1); push(0, 0, 0); push_line(3, 1); push(0, 0, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            cycle(s.vs, s.de, s.d);
            for (int i = 0; i < N; i++) begin
                checks++;
                if (obs[i] !== exp_vec(i)) begin
                    failures++;
                    $display("[TB] FAIL postreset_inst%0d: got %h need %h", i, obs[i], exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_random();
        stim_t s;
        for (int t = 0; t < 250; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) push(1, 1'($urandom), 8'($urandom));
            end else begin
                push_line(int'($urandom_range(1, 9)), 1);
                if ($urandom_range(0, 4) == 0) push(1, 1'($urandom), 8'($urandom));
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) push(0, 0, 8'($urandom));
            end
        end
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            cycle(s.vs, s.de, s.d);
            for (int i = 0; i < N; i++) begin
                checks++;
                if (obs[i] !== exp_vec(i)) begin
                    failures++;
                    $display("[TB] FAIL random_inst%0d: got %h need %h", i, obs[i], exp_vec(i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_packing();
        test_vsync();
        test_drop_saturation();
        test_reset_midword();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmos_pixel_packer.md
# cmos_pixel_packer

Parametrised successor to the camera-side 8→16 bit byte combiner. Packs RATIO consecutive IN_W-bit beats from a CMOS sensor port into one IN_W*RATIO-bit word, and tags each word with line and frame markers. Handles lines whose beat count is not a multiple of RATIO by either padding or dropping the partial word. Sits between the sensor input registers and the frame-buffer write FIFO, all in the pixel-clock domain.

## Interface
Parameters:
- IN_W, 8, input beat width in bits (1..16)
- RATIO, 2, input beats per output word (1..8)
- FIRST_LOW, 1, 1: first beat of a word lands in bits [IN_W-1:0]; 0: first beat lands in the top slice
- FLUSH_PARTIAL, 1, 1: pad and emit an incomplete word at line end; 0: drop it and count
- PAD_VALUE, 0, IN_W-bit value used to fill the unfilled slots of a flushed partial word

Ports (clock and reset first):
- pclk  in  1  pixel clock; the only clock
- rst  in  1  asynchronous, active-high reset
- vsync_i  in  1  frame sync, high during vertical blank
- de_i  in  1  beat valid / line active
- pdata_i  in  IN_W  input beat
- pdata_o  out  IN_W*RATIO  packed word
- de_o  out  1  one-cycle strobe per packed word
- sol_o  out  1  high with the first de_o word of each line
- sof_o  out  1  high with the first de_o word after a vsync_i assertion
- eol_o  out  1  one-cycle pulse, one per line end
- partial_o  out  1  high with a de_o word that contains pad slots
- line_words_o  out  16  word count of the most recently completed line
- drop_cnt_o  out  8  saturating count of dropped partial words

## Operation
- All outputs reset to 0. Reset is asynchronous assert with synchronous release. During reset the internal beat counter, accumulator, de_i delay flag, sof arm flag and running word counter clear.
- The beat counter cnt runs 0..RATIO-1 and is at least 1 bit wide. It advances on each pclk edge where de_i=1 and vsync_i=0, and wraps to 0 after RATIO-1. Each accepted beat is written into accumulator slot cnt.
  - FIRST_LOW=1: slot k occupies bits [k*IN_W +: IN_W].
  - FIRST_LOW=0: slot k occupies bits [(RATIO-1-k)*IN_W +: IN_W].
- Full word: at an accepted beat with cnt=RATIO-1, the word is registered with the current beat into its slot. On the same edge: de_o=1, partial_o=0, running word counter +1.
- Line end: the edge where de_i=0 and the delayed de_i=1, with vsync_i=0.
  - eol_o=1.
  - line_words_o ← running count, including any flushed word.
  - Running count clears.
  - cnt clears.
  - If cnt≠0 and FLUSH_PARTIAL=1: on the same edge, emit the accumulated slots with PAD_VALUE in slots ≥cnt; de_o=1, partial_o=1.
  - If cnt≠0 and FLUSH_PARTIAL=0: no word is emitted; drop_cnt_o +1, saturating at 255.
- sol_o=1 with the first de_o word after a line end, after reset, or after vsync_i.
- sof arm flag sets while vsync_i=1. sof_o=1 with the first de_o word while armed; the flag clears on that word.
- vsync_i=1 overrides de_i:
  - cnt, the accumulator, the de_i delay flag and the running count clear.
  - No flush, no eol_o, no drop count.
  - de_i is ignored.
- pdata_o holds its last value between strobes. de_o, sol_o, sof_o, eol_o and partial_o are single-cycle pulses.
- RATIO=1: every accepted beat gives a word with 1-cycle latency. partial_o and drop_cnt_o stay 0.
- A new line may start on the cycle right after a line end. Minimum blank between lines is 1 cycle.

## Timing
- Latency: last beat sampled at edge E → pdata_o/de_o valid from E to E+1. Flushed partial word and eol_o appear after the line-end edge, which is 1 cycle after the last beat.
- Maximum throughput: one word every RATIO cycles. No backpressure; the downstream must always accept.
- Simultaneous vsync_i rising edge and de_i falling edge: vsync wins, so no eol_o.
- Line with zero beats cannot occur, because eol_o requires de_i to have been high.

## Test plan
- RATIO=2, FIRST_LOW=1, line beats 11,22,33,44 → de_o on beats 2 and 4, words 16'h2211 then 16'h4433. sol_o with the first word. eol_o 1 cycle after de_i falls. line_words_o=2.
- RATIO=2, FIRST_LOW=0, same beats → 16'h1122, 16'h3344.
- RATIO=4, IN_W=8, FLUSH_PARTIAL=1, PAD_VALUE=8'hFF, beats 01..06 → 32'h04030201, then 32'hFFFF0605 with partial_o=1 and eol_o on the same cycle. line_words_o=2.
- RATIO=4, FLUSH_PARTIAL=0, 6-beat line, repeated 300 times → one word per line, no partial output. drop_cnt_o saturates at 255.
- vsync_i pulse, then a 4-beat line at RATIO=2 → sof_o and sol_o on the first word only. A vsync_i raised mid-line after 1 beat gives no flush, no eol_o and no drop; the next line starts at slot 0.
- rst asserted mid-word (cnt=1) → all outputs 0 immediately. After release, the next line packs from slot 0.
